// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: divides the system clock down to the pixel rate and
// produces registered pixel coordinates, active-video flag, sync pulses and strobes.
module vga_timing_gen #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned H_VISIBLE = 640,
    parameter int unsigned H_FRONT   = 16,
    parameter int unsigned H_SYNC    = 96,
    parameter int unsigned H_BACK    = 48,
    parameter int unsigned V_VISIBLE = 480,
    parameter int unsigned V_FRONT   = 10,
    parameter int unsigned V_SYNC    = 2,
    parameter int unsigned V_BACK    = 33
) (
    input  logic       clk,
    input  logic       rst_n,
    output logic [9:0] h_cnt,
    output logic [9:0] v_cnt,
    output logic       valid,
    output logic       hsync,
    output logic       vsync,
    output logic       pixel_tick,
    output logic       line_start,
    output logic       frame_start
);

    localparam int unsigned H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS    = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS    = 10'(V_VISIBLE);
    localparam logic [9:0] HS_START = 10'(H_VISIBLE + H_FRONT);
    localparam logic [9:0] HS_END   = 10'(H_VISIBLE + H_FRONT + H_SYNC);
    localparam logic [9:0] VS_START = 10'(V_VISIBLE + V_FRONT);
    localparam logic [9:0] VS_END   = 10'(V_VISIBLE + V_FRONT + V_SYNC);

    logic [DIV_W-1:0] div_q, div_d;
    logic [9:0]       h_q, h_d, v_q, v_d;
    logic [9:0]       h_nxt, v_nxt;
    logic             valid_q, valid_d;
    logic             hsync_q, hsync_d;
    logic             vsync_q, vsync_d;
    logic             tick_q, tick_d;
    logic             line_q, line_d;
    logic             frame_q, frame_d;
    logic             advance;

    always_comb begin
        advance = (div_q == DIV_LAST);
        h_nxt   = (h_q == H_LAST) ? '0 : h_q + 10'd1;
        v_nxt   = v_q;
        if (h_q == H_LAST) begin
            v_nxt = (v_q == V_LAST) ? '0 : v_q + 10'd1;
        end

        div_d   = div_q + DIV_W'(1);
        h_d     = h_q;
        v_d     = v_q;
        valid_d = valid_q;
        hsync_d = hsync_q;
        vsync_d = vsync_q;

        // Decode from the next-state counters so flags line up with the coordinates they accompany.
        if (advance) begin
            div_d   = '0;
            h_d     = h_nxt;
            v_d     = v_nxt;
            valid_d = (h_nxt < H_VIS) && (v_nxt < V_VIS);
            hsync_d = !((h_nxt >= HS_START) && (h_nxt < HS_END));
            vsync_d = !((v_nxt >= VS_START) && (v_nxt < VS_END));
        end

        tick_d  = advance;
        line_d  = advance && (h_nxt == '0);
        frame_d = line_d && (v_nxt == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q   <= '0;
            h_q     <= H_LAST;
            v_q     <= V_LAST;
            valid_q <= 1'b0;
            hsync_q <= 1'b1;
            vsync_q <= 1'b1;
            tick_q  <= 1'b0;
            line_q  <= 1'b0;
            frame_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            h_q     <= h_d;
            v_q     <= v_d;
            valid_q <= valid_d;
            hsync_q <= hsync_d;
            vsync_q <= vsync_d;
            tick_q  <= tick_d;
            line_q  <= line_d;
            frame_q <= frame_d;
        end
    end

    assign h_cnt       = h_q;
    assign v_cnt       = v_q;
    assign valid       = valid_q;
    assign hsync       = hsync_q;
    assign vsync       = vsync_q;
    assign pixel_tick  = tick_q;
    assign line_start  = line_q;
    assign frame_start = frame_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: three instances (default, CLK_DIV=1, small geometry) checked
// every cycle against an arithmetic raster model, with random asynchronous resets.
`timescale 1ns/1ps
module tb_vga_timing_gen;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;
    longint edges;

    logic [9:0] h4, v4, h1, v1, hs_, vs_;
    logic valid4, hsync4, vsync4, pt4, ls4, fs4;
    logic valid1, hsync1, vsync1, pt1, ls1, fs1;
    logic valids, hsyncs, vsyncs, pts, lss, fss;

    vga_timing_gen u_dut4 (
        .clk(clk), .rst_n(rst_n), .h_cnt(h4), .v_cnt(v4), .valid(valid4),
        .hsync(hsync4), .vsync(vsync4), .pixel_tick(pt4), .line_start(ls4),
        .frame_start(fs4)
    );

    vga_timing_gen #(.CLK_DIV(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .h_cnt(h1), .v_cnt(v1), .valid(valid1),
        .hsync(hsync1), .vsync(vsync1), .pixel_tick(pt1), .line_start(ls1),
        .frame_start(fs1)
    );

    vga_timing_gen #(
        .CLK_DIV(3), .H_VISIBLE(12), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
        .V_VISIBLE(5), .V_FRONT(2), .V_SYNC(2), .V_BACK(3)
    ) u_duts (
        .clk(clk), .rst_n(rst_n), .h_cnt(hs_), .v_cnt(vs_), .valid(valids),
        .hsync(hsyncs), .vsync(vsyncs), .pixel_tick(pts), .line_start(lss),
        .frame_start(fss)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Expected outputs after e clock edges since reset release, from pixel arithmetic.
    function automatic logic [25:0] ref_out(input longint e, input int cd,
                                            input int hv, input int hf, input int hs, input int hb,
                                            input int vv, input int vf, input int vs, input int vb);
        longint ht, vt, frame, a, idx, x, y;
        logic pt, ls, fs, vld, hsy, vsy;
        ht    = hv + hf + hs + hb;
        vt    = vv + vf + vs + vb;
        frame = ht * vt;
        a     = e / cd;
        idx   = (a + frame - 1) % frame;
        x     = idx % ht;
        y     = idx / ht;
        pt    = (e > 0) && (e % cd == 0);
        ls    = pt && (x == 0);
        fs    = ls && (y == 0);
        vld   = (x < hv) && (y < vv);
        hsy   = !((x >= hv + hf) && (x < hv + hf + hs));
        vsy   = !((y >= vv + vf) && (y < vv + vf + vs));
        return {10'(x), 10'(y), vld, hsy, vsy, pt, ls, fs};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) edges <= 0;
        else        edges <= edges + 1;
    end

    longint last4, last1, lasts;
    bit     last4_ok, last1_ok, lasts_ok;

    always @(negedge clk) begin
        check("d4_raster", {6'd0, h4, v4, valid4, hsync4, vsync4, pt4, ls4, fs4},
              {6'd0, ref_out(edges, 4, 640, 16, 96, 48, 480, 10, 2, 33)});
        check("d1_raster", {6'd0, h1, v1, valid1, hsync1, vsync1, pt1, ls1, fs1},
              {6'd0, ref_out(edges, 1, 640, 16, 96, 48, 480, 10, 2, 33)});
        check("ds_raster", {6'd0, hs_, vs_, valids, hsyncs, vsyncs, pts, lss, fss},
              {6'd0, ref_out(edges, 3, 12, 2, 3, 3, 5, 2, 2, 3)});
        if (!rst_n) begin
            last4_ok = 0;
            last1_ok = 0;
            lasts_ok = 0;
        end else begin
            if (ls4) begin
                if (last4_ok) check("d4_line_period", 32'(edges - last4), 32'd3200);
                last4 = edges;
                last4_ok = 1;
            end
            if (ls1) begin
                if (last1_ok) check("d1_line_period", 32'(edges - last1), 32'd800);
                last1 = edges;
                last1_ok = 1;
            end
            if (fss) begin
                if (lasts_ok) check("ds_frame_period", 32'(edges - lasts), 32'd720);
                lasts = edges;
                lasts_ok = 1;
            end
        end
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n   = 1'b0;
        repeat (3) @(posedge clk);
        #3;
        check("rst_h", 32'(h4), 32'd799);
        check("rst_v", 32'(v4), 32'd524);
        check("rst_flags", {26'd0, valid4, hsync4, vsync4, pt4, ls4, fs4}, 32'b011000);
        rst_n = 1'b1;

        repeat (3) @(posedge clk);
        #1;
        check("pre_adv_hv", {12'd0, h4, v4}, {12'd0, 10'd799, 10'd524});
        check("d1_first_tick", 32'(pt1), 32'd1);
        @(posedge clk);
        #1;
        check("adv_hv", {12'd0, h4, v4}, 32'd0);
        check("adv_strobes", {28'd0, valid4, pt4, ls4, fs4}, 32'b1111);
        @(posedge clk);
        #1;
        check("adv_strobes_clear", {29'd0, pt4, ls4, fs4}, 32'b000);

        for (int unsigned i = 0; i < 4; i++) begin
            repeat ($urandom_range(1500, 7000)) @(posedge clk);
            #($urandom_range(1, 3));
            rst_n = 1'b0;
            #1;
            check("async_rst_d4", {6'd0, h4, v4, valid4, hsync4, vsync4, pt4, ls4, fs4},
                  {6'd0, 10'd799, 10'd524, 6'b011000});
            check("async_rst_ds", {6'd0, hs_, vs_, valids, hsyncs, vsyncs, pts, lss, fss},
                  {6'd0, 10'd19, 10'd11, 6'b011000});
            repeat ($urandom_range(1, 5)) @(posedge clk);
            #3;
            rst_n = 1'b1;
        end

        repeat (4000) @(posedge clk);
        @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
